lfm_chirp_tx: RTL and testbench

- Transmit-side counterpart of the 64-tap pulse-compression receiver.
- Generates one linear-FM (chirp) burst of LEN complex baseband samples (signed I/Q, WIDTH bits) per trigger, using a quadratic-phase DDS.
- Output feeds the DAC/upconverter path and, in loopback, the receiver's signal_I/signal_Q inputs.
- Default waveform is the complex conjugate, time-reversed, of the receiver's matched-filter taps (within LUT rounding), so loopback produces the compressed peak.

---
 rtl/lfm_chirp_tx.sv | 212 +++++++++++++++++++++
 tb/tb_lfm_chirp_tx.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfm_chirp_tx.sv
// Linear-FM chirp burst generator: one LEN-sample complex burst per trigger via quadratic-phase DDS.
// Latency: sample n leaves tx_I/tx_Q exactly 2 clocks after the sample_en cycle that consumed it.
// Backpressure: none downstream; sample_en low stalls all accumulators and emits nothing.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   start             one-cycle trigger, honoured only in IDLE
//   sample_en         sample-rate strobe, one sample consumed per high cycle in TX
//   tx_I, tx_Q        signed baseband sample (cos, sin), forced to 0 when tx_valid is low
//   tx_valid          one-clock strobe per burst sample
//   busy              high in TX and GAP
//   done              pulse coincident with the last valid sample of a burst
//   pri_overrun       (only with LFM_CHIRP_PRI_AUTO_EN) sticky: an auto-trigger was dropped
//
// Optional feature macro: LFM_CHIRP_PRI_AUTO_EN adds a free-running PRI auto-trigger.
// The quarter-wave table below holds round(2047*sin(2*pi*k/256)), k = 0..64, so it matches
// WIDTH = 12 and LUT_AW = 8.
module lfm_chirp_tx #(
   parameter int WIDTH      = 12,
   parameter int LEN        = 64,
   parameter int PHASE_W    = 16,
   parameter int LUT_AW     = 8,
   parameter int F0         = -32768,
   parameter int K          = 1024,
   parameter int GAP_CYCLES = 8
`ifdef LFM_CHIRP_PRI_AUTO_EN
   ,parameter int PRI       = 256
`endif
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    sample_en,
   output logic signed [WIDTH-1:0] tx_I,
   output logic signed [WIDTH-1:0] tx_Q,
   output logic                    tx_valid,
   output logic                    busy,
   output logic                    done
`ifdef LFM_CHIRP_PRI_AUTO_EN
   ,output logic                   pri_overrun
`endif
);

   localparam int N_W   = $clog2(LEN);
   localparam int GAP_W = $clog2(GAP_CYCLES + 1);
   localparam logic [PHASE_W-1:0] F0_W     = PHASE_W'(F0);
   localparam logic [PHASE_W-1:0] K_W      = PHASE_W'(K);
   localparam logic [N_W-1:0]     N_LAST   = N_W'(LEN - 1);
   localparam logic [GAP_W-1:0]   GAP_LAST = GAP_W'(GAP_CYCLES - 1);

   // First quadrant of the sine wave, inclusive of both end points.
   localparam logic [10:0] QTAB [0:64] = '{
      11'd0,    11'd50,   11'd100,  11'd151,  11'd201,  11'd251,  11'd300,  11'd350,
      11'd399,  11'd449,  11'd497,  11'd546,  11'd594,  11'd642,  11'd690,  11'd737,
      11'd783,  11'd830,  11'd875,  11'd920,  11'd965,  11'd1009, 11'd1052, 11'd1095,
      11'd1137, 11'd1179, 11'd1219, 11'd1259, 11'd1299, 11'd1337, 11'd1375, 11'd1411,
      11'd1447, 11'd1483, 11'd1517, 11'd1550, 11'd1582, 11'd1614, 11'd1644, 11'd1674,
      11'd1702, 11'd1729, 11'd1756, 11'd1781, 11'd1805, 11'd1828, 11'd1850, 11'd1871,
      11'd1891, 11'd1910, 11'd1927, 11'd1944, 11'd1959, 11'd1973, 11'd1986, 11'd1997,
      11'd2008, 11'd2017, 11'd2025, 11'd2032, 11'd2037, 11'd2041, 11'd2045, 11'd2046,
      11'd2047
   };

   // Full-circle sine from the quarter table: odd quadrants mirror the index,
   // the lower half-circle negates. Magnitudes never exceed 2047, so the
   // negation can never produce the most negative code.
   function automatic logic signed [WIDTH-1:0] lut_sin(input logic [7:0] a);
      logic [6:0]              idx;
      logic signed [WIDTH-1:0] m;
      idx = a[6] ? (7'd64 - {1'b0, a[5:0]}) : {1'b0, a[5:0]};
      m   = WIDTH'(QTAB[idx]);
      return a[7] ? -m : m;
   endfunction

   // cos(x) = sin(x + quarter turn)
   function automatic logic signed [WIDTH-1:0] lut_cos(input logic [7:0] a);
      return lut_sin(a + 8'd64);
   endfunction

   typedef enum logic [1:0] {S_IDLE, S_TX, S_GAP} state_t;

   state_t             state_q, state_d;
   logic [PHASE_W-1:0] phase_q, freq_q;
   logic [N_W-1:0]     n_q;
   logic [GAP_W-1:0]   gap_q;
   logic               consume;
   logic               trig;
   logic [LUT_AW-1:0]  lut_addr;

   // LUT-read stage
   logic                    v1_q, last1_q;
   logic signed [WIDTH-1:0] cos1_q, sin1_q;

`ifdef LFM_CHIRP_PRI_AUTO_EN
   localparam int PRI_W = $clog2(PRI);
   logic [PRI_W-1:0] pri_q;
   logic             auto_trig;

   always_ff @(posedge clk) begin
      if (rst) begin
         pri_q <= '0;
      end else begin
         pri_q <= (pri_q == PRI_W'(PRI - 1)) ? '0 : pri_q + PRI_W'(1);
      end
   end

   assign auto_trig = (pri_q == '0);
   assign trig      = start | auto_trig;

   // An auto-trigger landing outside IDLE is lost; remember that it happened.
   always_ff @(posedge clk) begin
      if (rst) begin
         pri_overrun <= 1'b0;
      end else if (auto_trig && state_q != S_IDLE) begin
         pri_overrun <= 1'b1;
      end
   end
`else
   assign trig = start;
`endif

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      consume = 1'b0;
      case (state_q)
         S_IDLE: if (trig) state_d = S_TX;
         S_TX: begin
            if (sample_en) begin
               consume = 1'b1;
               if (n_q == N_LAST) state_d = S_GAP;
            end
         end
         S_GAP: if (gap_q == GAP_LAST) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Quadratic-phase DDS: frequency ramps linearly, phase integrates it.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q <= '0;
         freq_q  <= '0;
         n_q     <= '0;
         gap_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (trig) begin
                  phase_q <= '0;
                  freq_q  <= F0_W;
                  n_q     <= '0;
               end
            end
            S_TX: begin
               gap_q <= '0;
               if (consume) begin
                  phase_q <= phase_q + freq_q;
                  freq_q  <= freq_q + K_W;
                  n_q     <= n_q + N_W'(1);
               end
            end
            S_GAP:   gap_q <= gap_q + GAP_W'(1);
            default: gap_q <= '0;
         endcase
      end
   end

   assign lut_addr = phase_q[PHASE_W-1 -: LUT_AW];

   // Stage 1: registered LUT read of the sample being consumed.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q    <= 1'b0;
         last1_q <= 1'b0;
         cos1_q  <= '0;
         sin1_q  <= '0;
      end else begin
         v1_q    <= consume;
         last1_q <= consume && (n_q == N_LAST);
         cos1_q  <= lut_cos(lut_addr);
         sin1_q  <= lut_sin(lut_addr);
      end
   end

   // Stage 2: output register; data is zeroed whenever it carries no sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_valid <= 1'b0;
         done     <= 1'b0;
         tx_I     <= '0;
         tx_Q     <= '0;
      end else begin
         tx_valid <= v1_q;
         done     <= last1_q;
         tx_I     <= v1_q ? cos1_q : '0;
         tx_Q     <= v1_q ? sin1_q : '0;
      end
   end

   assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_lfm_chirp_tx.sv
// Directed bench for lfm_chirp_tx: reset state, continuous and strobed bursts against a
// floating-point golden model, ignored mid-burst triggers, back-to-back retrigger, reset abort.
module tb_lfm_chirp_tx;
   localparam int WIDTH = 12;
   localparam int LEN   = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic sample_en = 1'b0;
   logic signed [WIDTH-1:0] tx_I, tx_Q;
   logic tx_valid, busy, done;
`ifdef LFM_CHIRP_PRI_AUTO_EN
   logic pri_overrun;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int vi[$], vq[$], vc[$], vd[$];
   int done_cnt = 0;
   int last_done_cyc = -1;
   int s_cyc = 0;
   int idle_cyc = 0;

   lfm_chirp_tx #(.WIDTH(WIDTH), .LEN(LEN)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .sample_en(sample_en),
      .tx_I     (tx_I),
      .tx_Q     (tx_Q),
      .tx_valid (tx_valid),
      .busy     (busy),
      .done     (done)
`ifdef LFM_CHIRP_PRI_AUTO_EN
      ,.pri_overrun(pri_overrun)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (tx_valid) begin
         vi.push_back(int'(tx_I));
         vq.push_back(int'(tx_Q));
         vc.push_back(cyc);
         vd.push_back(int'(done));
      end
      if (done) begin
         done_cnt++;
         last_done_cyc = cyc;
      end
   end

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int rnd(input real x);
      if (x >= 0.0) return int'($floor(x + 0.5));
      return -int'($floor(-x + 0.5));
   endfunction

   // Golden sample n: 16-bit phase/frequency recurrence, then an ideal rounded cos/sin.
   task automatic model(input int n, output int ei, output int eq);
      logic [15:0] ph;
      logic [15:0] fr;
      logic [7:0]  a;
      real         ang;
      ph = 16'h0000;
      fr = 16'h8000;
      for (int m = 0; m < n; m++) begin
         ph = ph + fr;
         fr = fr + 16'd1024;
      end
      a   = ph[15:8];
      ang = 2.0 * 3.14159265358979 * real'(int'(a)) / 256.0;
      ei  = rnd(2047.0 * $cos(ang));
      eq  = rnd(2047.0 * $sin(ang));
   endtask

   task automatic clear_mon();
      vi.delete();
      vq.delete();
      vc.delete();
      vd.delete();
      done_cnt      = 0;
      last_done_cyc = -1;
   endtask

   // Pulse start for one cycle; busy must rise exactly one clock later.
   task automatic do_start();
      start = 1'b1;
      s_cyc = cyc;
      @(negedge clk);
      chk("busy_before_rise", int'(busy), 0);
      tick();
      start = 1'b0;
      chk("busy_rise", int'(busy), 1);
   endtask

   // Run until the burst has finished and the FSM is back in IDLE.
   // poke: fire start mid-TX and in the last GAP cycle (both must be ignored).
   // chain: leave start high in the very first IDLE cycle.
   task automatic drain(input int period, input bit poke, input bit chain);
      int k;
      bit fin;
      k   = 0;
      fin = 1'b0;
      while (!fin && k < 3000) begin
         sample_en = (k % period == 0);
         start = poke && (k == 10 || (last_done_cyc >= 0 && cyc == last_done_cyc + 6));
         tick();
         k++;
         if (last_done_cyc >= 0 && !busy) fin = 1'b1;
      end
      sample_en = 1'b0;
      start     = 1'b0;
      chk("burst_terminates", int'(fin), 1);
      if (fin) begin
         idle_cyc = cyc;
         // last consume c, done at c+2, GAP c+1..c+8, IDLE from c+9
         chk("idle_after_done", idle_cyc - last_done_cyc, 7);
         if (chain) start = 1'b1;
      end
   endtask

   task automatic check_burst(input int period);
      int ei, eq;
      chk("sample_count", vi.size(), LEN);
      chk("done_pulses", done_cnt, 1);
      chk("first_latency", (vc.size() > 0) ? vc[0] - s_cyc : -1, 3);
      if (vi.size() == LEN) begin
         chk("done_on_last", vd[LEN-1], 1);
         chk("done_not_early", vd[LEN-2], 0);
         for (int n = 0; n < LEN; n++) begin
            model(n, ei, eq);
            chk($sformatf("golden_I[%0d]", n), vi[n], ei);
            chk($sformatf("golden_Q[%0d]", n), vq[n], eq);
            if (n > 0) chk($sformatf("spacing[%0d]", n), vc[n] - vc[n-1], period);
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      rst = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      chk("rst_tx_valid", int'(tx_valid), 0);
      chk("rst_tx_I", int'(tx_I), 0);
      chk("rst_tx_Q", int'(tx_Q), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);

      // Reset wins over a simultaneous start
      start = 1'b1;
      tick();
      rst   = 1'b0;
      start = 1'b0;
      @(negedge clk);
      chk("rst_beats_start", int'(busy), 0);
      tick();

      // Burst 1: sample_en tied high, plus hand-computed samples.
      // Address of sample n is (2n(n-1) - 128n) mod 256:
      //   n=0 -> 0, n=1 -> 128, n=2 -> 4, n=32 -> 192, n=63 -> 4.
      clear_mon();
      do_start();
      drain(1, 1'b0, 1'b0);
      check_burst(1);
      if (vi.size() == LEN) begin
         chk("s0_I", vi[0], 2047);
         chk("s0_Q", vq[0], 0);
         chk("s1_I", vi[1], -2047);
         chk("s1_Q", vq[1], 0);
         chk("s2_I", vi[2], 2037);
         chk("s2_Q", vq[2], 201);
         chk("s32_I", vi[32], 0);
         chk("s32_Q", vq[32], -2047);
         chk("s63_I", vi[63], 2037);
         chk("s63_Q", vq[63], 201);
      end

      // Burst 2: sample_en every 4th clock
      repeat (3) tick();
      clear_mon();
      do_start();
      drain(4, 1'b0, 1'b0);
      check_burst(4);

      // Burst 3: start poked in TX and GAP, then retriggered on IDLE entry
      repeat (3) tick();
      clear_mon();
      do_start();
      drain(1, 1'b1, 1'b1);
      check_burst(1);
      tick();
      start = 1'b0;
      chk("start_on_idle_entry", int'(busy), 1);
      s_cyc = idle_cyc;
      clear_mon();
      drain(1, 1'b0, 1'b0);
      check_burst(1);

      // Burst 5: reset while sample 20 is on the output
      repeat (4) tick();
      clear_mon();
      do_start();
      sample_en = 1'b1;
      for (int g = 0; g < 200 && vi.size() < 20; g++) tick();
      rst = 1'b1;
      tick();
      @(negedge clk);
      chk("abort_tx_valid", int'(tx_valid), 0);
      chk("abort_tx_I", int'(tx_I), 0);
      chk("abort_tx_Q", int'(tx_Q), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_sample_count", vi.size(), 21);
      rst = 1'b0;
      repeat (10) tick();
      @(negedge clk);
      chk("abort_no_resume", vi.size(), 21);
      chk("abort_no_done", done_cnt, 0);
      chk("abort_idle", int'(busy), 0);
      tick();
      sample_en = 1'b0;
      clear_mon();
      do_start();
      drain(1, 1'b0, 1'b0);
      check_burst(1);
      if (vi.size() == LEN) begin
         chk("after_rst_s0_I", vi[0], 2047);
         chk("after_rst_s0_Q", vq[0], 0);
      end

      repeat (2) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
